// File: rtl/wb_host_pkg.sv
// Shared definitions for the Wishbone host master: FSM states and default widths/limits.
package wb_host_pkg;

  localparam int unsigned WB_ADDR_W         = 32;
  localparam int unsigned WB_DATA_W         = 32;
  localparam int unsigned WB_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/wb_watchdog.sv
// Bus watchdog: counts cycles while enabled and flags the cycle on which LIMIT is reached.
module wb_watchdog #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (LIMIT == 0) begin : g_disabled
      logic unused_inputs;
      assign unused_inputs = &{1'b0, clk, rst, clear, enable};
      assign expired = 1'b0;
    end else begin : g_enabled
      localparam int unsigned W = $clog2(LIMIT + 1);
      logic [W-1:0] count;

      // count holds completed cycles, so the edge ending cycle LIMIT sees count == LIMIT-1
      always_ff @(posedge clk) begin
        if (rst || clear) begin
          count <= '0;
        end else if (enable && (count != W'(LIMIT))) begin
          count <= count + 1'b1;
        end
      end

      assign expired = enable && (count == W'(LIMIT - 1));
    end
  endgenerate

endmodule

// File: rtl/wb_host_master.sv
// Wishbone classic single-transfer master: one valid/ready command becomes one bus cycle and one response.
module wb_host_master
  import wb_host_pkg::*;
#(
  parameter int unsigned ADDR_W         = WB_ADDR_W,
  parameter int unsigned DATA_W         = WB_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = WB_TIMEOUT_CYCLES
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_data,
  input  logic [DATA_W/8-1:0] cmd_sel,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_err,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [DATA_W/8-1:0] wbm_sel_o,
  output logic [ADDR_W-1:0]   wbm_adr_o,
  output logic [DATA_W-1:0]   wbm_dat_o,
  input  logic [DATA_W-1:0]   wbm_dat_i,
  input  logic                wbm_ack_i
);

  state_t state, state_next;
  logic   accept, ack_take, abort, wd_en, expired;

  assign wd_en = (state == S_BUS);

  wb_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .clear   (accept),
    .enable  (wd_en),
    .expired (expired)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    ack_take   = 1'b0;
    abort      = 1'b0;
    unique case (state)
      S_IDLE: if (cmd_valid) begin
        accept     = 1'b1;
        state_next = S_BUS;
      end
      // ack has priority over a watchdog expiry on the same edge
      S_BUS: if (wbm_ack_i) begin
        ack_take   = 1'b1;
        state_next = S_RESP;
      end else if (expired) begin
        abort      = 1'b1;
        state_next = S_RESP;
      end
      S_RESP: if (rsp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // All outputs are registered, decoded from the next state
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cmd_ready <= 1'b1;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      cmd_ready <= (state_next == S_IDLE);
      wbm_cyc_o <= (state_next == S_BUS);
      wbm_stb_o <= (state_next == S_BUS);
      rsp_valid <= (state_next == S_RESP);
      if (accept) begin
        wbm_we_o  <= cmd_we;
        wbm_sel_o <= cmd_sel;
        wbm_adr_o <= cmd_addr;
        wbm_dat_o <= cmd_data;
      end
      if (ack_take) begin
        rsp_data <= wbm_we_o ? '0 : wbm_dat_i;
        rsp_err  <= 1'b0;
      end else if (abort) begin
        rsp_data <= '0;
        rsp_err  <= 1'b1;
      end
    end
  end

endmodule
